// File: rtl/mlp_stream_coprocessor_pkg.sv
// mlp_pkg: shared sizes, packet word offsets and FSM state codes for the MLP coprocessor
package mlp_pkg;
  localparam int NUM_ROWS = 64;
  localparam int NUM_FEATURES = 7;
  localparam int NUM_HIDDEN = 2;
  localparam int ELEM_W = 8;
  localparam logic [8:0] HID_W_BASE = 9'd0;
  localparam logic [8:0] OUT_W_BASE = 9'd16;
  localparam logic [8:0] DATA_BASE = 9'd19;
  localparam logic [8:0] IN_WORDS = 9'd467;
  localparam logic [1:0] READ = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
endpackage

// File: rtl/mlp_stream_coprocessor_sigmoid_lut.sv
// sigmoid_lut: 256-entry ROM of min(255, round(256/(1+exp(-(k-128)/32)))), folded at elaboration
module sigmoid_lut
  import mlp_pkg::*;
(
  input  logic [ELEM_W-1:0] addr,
  output logic [ELEM_W-1:0] value
);
  function automatic logic [ELEM_W-1:0] sig_val(input int k);
    real s;
    int v;
    s = 256.0 / (1.0 + $exp(-($itor(k) - 128.0) / 32.0));
    v = $rtoi(s + 0.5);
    return v > 255 ? 8'd255 : v[7:0];
  endfunction
  logic [ELEM_W-1:0] rom [256];
  for (genvar k = 0; k < 256; k++) begin : g_rom
    assign rom[k] = sig_val(k);
  end
  assign value = rom[addr];
endmodule

// File: rtl/mlp_stream_coprocessor.sv
// mlp_stream_coprocessor: AXI4-Stream 7-2-1 MLP evaluator; reads weights+dataset, computes 64 rows,
// streams the 64 predictions back. One feature per cycle for both hidden neurons, 8 cycles per row.
module mlp_stream_coprocessor
  import mlp_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);
  logic [1:0] state;
  logic [8:0] in_cnt, dptr, w_idx;
  logic [5:0] row, out_cnt;
  logic [2:0] feat;
  logic [18:0] acc0, acc1;
  logic [17:0] out_sum;
  logic [ELEM_W-1:0] x, w0, w1, a0, a1, h0, h1, y;
  logic s_ready, in_fire, out_fire, in_last;
  logic [ELEM_W-1:0] mem [IN_WORDS];
  logic [ELEM_W-1:0] res [NUM_ROWS];
  logic unused;
  assign unused = ^{S_AXIS_TLAST, S_AXIS_TDATA[31:8]};
  assign in_fire = s_ready && S_AXIS_TVALID;
  assign in_last = in_cnt == IN_WORDS - 9'd1;
  assign out_fire = state == WRITE && M_AXIS_TREADY;
  assign w_idx = HID_W_BASE + {6'b0, feat} + 9'd1;
  assign x = mem[dptr];
  assign w0 = mem[w_idx];
  assign w1 = mem[w_idx + 9'd8];
  // Pre-activation >> 8, saturated to the 8-bit LUT address range
  assign a0 = |acc0[18:16] ? 8'hFF : acc0[15:8];
  assign a1 = |acc1[18:16] ? 8'hFF : acc1[15:8];
  sigmoid_lut u_sig0 (.addr(a0), .value(h0));
  sigmoid_lut u_sig1 (.addr(a1), .value(h1));
  assign out_sum = {2'b0, mem[OUT_W_BASE], 8'b0}
                 + {10'b0, mem[OUT_W_BASE + 9'd1]} * {10'b0, h0}
                 + {10'b0, mem[OUT_W_BASE + 9'd2]} * {10'b0, h1};
  assign y = |out_sum[17:16] ? 8'hFF : out_sum[15:8];
  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = state == WRITE;
  assign M_AXIS_TLAST = state == WRITE && out_cnt == 6'd63;
  assign M_AXIS_TDATA = state == WRITE ? {24'b0, res[out_cnt]} : 32'b0;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= READ;
      in_cnt <= '0;
      dptr <= '0;
      row <= '0;
      feat <= '0;
      out_cnt <= '0;
      acc0 <= '0;
      acc1 <= '0;
      s_ready <= 1'b0;
    end else begin
      case (state)
        READ: begin
          s_ready <= !(in_fire && in_last);
          dptr <= DATA_BASE;
          row <= '0;
          feat <= '0;
          if (in_fire) begin
            in_cnt <= in_last ? 9'd0 : in_cnt + 9'd1;
            if (in_last) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          feat <= feat + 3'd1;
          if (feat != 3'd7) begin
            acc0 <= (feat == 3'd0 ? {3'b0, mem[HID_W_BASE], 8'b0} : acc0) + {11'b0, x} * {11'b0, w0};
            acc1 <= (feat == 3'd0 ? {3'b0, mem[HID_W_BASE + 9'd8], 8'b0} : acc1) + {11'b0, x} * {11'b0, w1};
            dptr <= dptr + 9'd1;
          end else begin
            row <= row + 6'd1;
            if (row == 6'd63) state <= WRITE;
          end
        end
        default: if (out_fire) begin
          out_cnt <= out_cnt + 6'd1;
          if (out_cnt == 6'd63) begin
            state <= READ;
            s_ready <= 1'b1;
          end
        end
      endcase
    end
  always_ff @(posedge ACLK) begin
    if (in_fire) mem[in_cnt] <= S_AXIS_TDATA[ELEM_W-1:0];
    if (state == COMPUTE && feat == 3'd7) res[row] <= y;
  end
endmodule

// File: tb/tb_mlp_stream_coprocessor.sv
// tb_mlp_stream_coprocessor: directed packets with hand-computed predictions for the MLP coprocessor
module tb_mlp_stream_coprocessor;
  logic ACLK = 0, ARESETN = 0;
  logic S_AXIS_TREADY, S_AXIS_TLAST = 0, S_AXIS_TVALID = 0;
  logic [31:0] S_AXIS_TDATA = 0;
  logic M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY = 0;
  logic [31:0] M_AXIS_TDATA;
  int checks = 0, errors = 0;
  logic [7:0] pkt [467];
  logic [7:0] exp_y [64];
  logic [31:0] got [64];
  logic got_last [64];

  mlp_stream_coprocessor dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic int sig(input int k);
    real s;
    int v;
    s = 256.0 / (1.0 + $exp(-($itor(k) - 128.0) / 32.0));
    v = $rtoi(s + 0.5);
    return v > 255 ? 255 : v;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 467; i++) pkt[i] = v;
  endtask

  task automatic build_row_pkt();
    fill(8'h00);
    pkt[1] = 8'h80;
    pkt[17] = 8'hFF;
    for (int r = 0; r < 64; r++) begin
      pkt[19 + 7 * r] = 8'(4 * r);
      exp_y[r] = 8'((255 * sig(2 * r)) >> 8);
    end
  endtask

  task automatic send_word(input logic [7:0] b, output bit ok);
    int n = 0;
    S_AXIS_TDATA = {24'hA5C3E1, b};
    S_AXIS_TVALID = 1;
    while (S_AXIS_TREADY !== 1'b1 && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    S_AXIS_TVALID = 0;
    ok = n < 100;
  endtask

  task automatic send_pkt(input int cnt, input bit gaps, output bit ok);
    bit w_ok;
    ok = 1;
    for (int i = 0; i < cnt; i++) begin
      if (gaps && i % 3 == 1) @(negedge ACLK);
      S_AXIS_TLAST = (i % 50 == 49);
      send_word(pkt[i], w_ok);
      ok = ok & w_ok;
    end
    S_AXIS_TLAST = 0;
  endtask

  task automatic recv(input bit toggle, output int n, output int bad);
    int cyc = 0;
    bit stall = 0;
    logic [32:0] held = '0;
    n = 0;
    bad = 0;
    while (n < 64 && cyc < 5000) begin
      M_AXIS_TREADY = toggle ? (cyc % 3 == 0) : 1'b1;
      if (stall && {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA} !== {1'b1, held}) bad++;
      stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = {M_AXIS_TLAST, M_AXIS_TDATA};
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got[n] = M_AXIS_TDATA;
        got_last[n] = M_AXIS_TLAST;
        n++;
      end
      @(negedge ACLK);
      cyc++;
    end
    M_AXIS_TREADY = 0;
  endtask

  task automatic run_pkt(input bit gaps, input bit toggle, output bit ok, output int n, output int bad);
    send_pkt(467, gaps, ok);
    recv(toggle, n, bad);
  endtask

  task automatic test_reset();
    ARESETN = 0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA} !== 35'b0) begin
      errors++;
      $display("FAIL reset_outputs tready=%b tvalid=%b tlast=%b tdata=%h expected all 0",
               S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA);
    end
    ARESETN = 1;
    @(negedge ACLK);
    checks++;
    if (S_AXIS_TREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready got %b expected 1", S_AXIS_TREADY);
    end
  endtask

  task automatic test_zeros();
    bit ok;
    int n, bad;
    fill(8'h00);
    for (int r = 0; r < 64; r++) exp_y[r] = 8'h00;
    send_pkt(467, 0, ok);
    S_AXIS_TVALID = 1;
    S_AXIS_TDATA = 32'h77;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (S_AXIS_TREADY !== 1'b0) begin
        errors++;
        $display("FAIL zeros_extra_word cycle %0d tready=%b expected 0", i, S_AXIS_TREADY);
      end
      @(negedge ACLK);
    end
    S_AXIS_TVALID = 0;
    recv(0, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL zeros_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL zeros_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
    checks++;
    if ({M_AXIS_TVALID, S_AXIS_TREADY} !== 2'b01) begin
      errors++;
      $display("FAIL zeros_after_write tvalid=%b tready=%b expected 0 1", M_AXIS_TVALID, S_AXIS_TREADY);
    end
  endtask

  task automatic test_bias_only();
    bit ok;
    int n, bad;
    for (int i = 0; i < 467; i++) pkt[i] = i < 19 ? 8'h00 : 8'(i * 37);
    pkt[16] = 8'h5A;
    for (int r = 0; r < 64; r++) exp_y[r] = 8'h5A;
    run_pkt(0, 0, ok, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL bias_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL bias_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
  endtask

  task automatic test_mid_sigmoid();
    bit ok;
    int n, bad;
    for (int i = 0; i < 467; i++) pkt[i] = i < 19 ? 8'h00 : 8'(i * 13 + 5);
    pkt[0] = 8'h80;
    pkt[8] = 8'h80;
    pkt[17] = 8'h80;
    for (int r = 0; r < 64; r++) exp_y[r] = 8'h40;
    run_pkt(0, 0, ok, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL mid_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL mid_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int n, bad;
    fill(8'hFF);
    for (int r = 0; r < 64; r++) exp_y[r] = 8'hFF;
    run_pkt(0, 0, ok, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL sat_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL sat_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
  endtask

  task automatic test_row_dependence();
    bit ok;
    int n, bad;
    build_row_pkt();
    run_pkt(0, 0, ok, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL rowdep_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL rowdep_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
  endtask

  task automatic test_back_to_back_handshake();
    bit ok;
    int n, bad;
    build_row_pkt();
    run_pkt(1, 1, ok, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL hs_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hs_stall_stability unstable_cycles=%0d expected 0", bad);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL hs_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    int n, bad;
    fill(8'hFF);
    send_pkt(200, 0, ok);
    ARESETN = 0;
    #1;
    checks++;
    if (S_AXIS_TREADY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tready got %b expected 0", S_AXIS_TREADY);
    end
    @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    build_row_pkt();
    run_pkt(0, 0, ok, n, bad);
    checks++;
    if (!ok || n !== 64) begin
      errors++;
      $display("FAIL midrst_count send_ok=%0d words=%0d expected 64", ok, n);
    end
    for (int r = 0; r < 64; r++) begin
      checks++;
      if ({got_last[r], got[r]} !== {r == 63, 24'h0, exp_y[r]}) begin
        errors++;
        $display("FAIL midrst_row%0d got last=%b data=%h expected last=%b data=%h", r, got_last[r], got[r], r == 63, exp_y[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_bias_only();
    test_mid_sigmoid();
    test_saturate();
    test_row_dependence();
    test_back_to_back_handshake();
    test_reset_midpacket();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlp_stream_coprocessor.md
Name: mlp_stream_coprocessor

Overview:
- AXI4-Stream coprocessor that evaluates a fixed 7-2-1 multilayer perceptron on a 64-sample dataset.
- Receives one 467-word packet holding the weights and the dataset, computes, then returns one 64-word packet of predictions.
- Sits between an AXI DMA MM2S channel (slave side) and an S2MM channel (master side) in the EE4218 project datapath.

Parameters:
- NUM_ROWS, 64, samples per packet (output word count).
- NUM_FEATURES, 7, features per sample.
- NUM_HIDDEN, 2, hidden neurons.
- ELEM_W, 8, element width in bits (unsigned 0.8 fixed point, value = byte/256).
- C_AXIS_TDATA_WIDTH, 32, stream data width.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TREADY  out  1  input word accepted when high together with TVALID.
- S_AXIS_TDATA  in  32  input word; only bits [7:0] are used.
- S_AXIS_TLAST  in  1  ignored; packet length is fixed by count.
- S_AXIS_TVALID  in  1  input word valid.
- M_AXIS_TVALID  out  1  output word valid.
- M_AXIS_TDATA  out  32  output word: {24'b0, y[7:0]}.
- M_AXIS_TLAST  out  1  high only on output word 63.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Input packet order, 467 words:
  - words 0-15: hidden weights, neuron j (j = 0,1) at words 8j..8j+7 = bias, w1..w7;
  - words 16-18: output layer bias, v1, v2;
  - words 19-466: dataset, row-major, row r feature i (i = 1..7) at word 19+7r+(i-1).
- States: READ (reset state), COMPUTE, WRITE.
- READ:
  - S_AXIS_TREADY = 1; a word is stored at each edge where TVALID && TREADY, and the input counter increments.
  - After word 466 is accepted, go to COMPUTE; TREADY is 0 from the next cycle on.
- COMPUTE: S_AXIS_TREADY = 0 and M_AXIS_TVALID = 0. For each row r:
  - Hidden pre-activation: p_j = bias_j*256 + sum_i x_ri*w_ji (19-bit unsigned accumulator).
  - Hidden input: a_j = min(p_j>>8, 255).
  - Hidden activation: h_j = SIG[a_j], where SIG[k] = min(255, round(256/(1+exp(-(k-128)/32)))).
  - Output: y_r = min((b_o*256 + v1*h_0 + v2*h_1)>>8, 255), stored in the result buffer.
  - Any MAC schedule is allowed; all 64 results must be ready within 2048 cycles of entering COMPUTE. Then go to WRITE.
- WRITE:
  - M_AXIS_TVALID = 1; M_AXIS_TDATA = result[out_cnt].
  - Advance on TVALID && TREADY. TDATA/TVALID/TLAST stay stable while TREADY = 0.
  - TLAST = (out_cnt == 63). After word 63 transfers, return to READ with counters cleared.
- Reset: asynchronous to READ. Counters = 0; S_AXIS_TREADY = 0 while reset is asserted and 1 from the first edge after release; M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA = 0.
  - Storage arrays are not cleared.
  - Reset mid-packet discards partial input or output; the next packet starts at word 0.
- Words offered after word 466 are not accepted until the next READ phase. Input TLAST never terminates early.

Decomposition:
- Package mlp_pkg: NUM_ROWS, NUM_FEATURES, NUM_HIDDEN, ELEM_W, word-offset constants (HID_W_BASE = 0, OUT_W_BASE = 16, DATA_BASE = 19, IN_WORDS = 467), state enum {READ, COMPUTE, WRITE}.
- One sub-module: sigmoid_lut (8-bit address in, 8-bit SIG value out, 256-entry ROM generated from the formula above).

Test Plan:
- All 467 words 0x00 -> a_j = 0, h = SIG[0] = 5; outputs are 64 x 0x00 with TLAST only on word 63.
- Hidden weights 0, b_o = 0x5A, v1 = v2 = 0, arbitrary data -> all 64 outputs 0x5A.
- Hidden biases 0x80, other hidden weights 0, v1 = 0x80, v2 = 0, b_o = 0 -> h_0 = SIG[128] = 128; every y = 0x40.
- All 467 words 0xFF -> a_j saturates to 255, h = 251; y saturates; all outputs 0xFF.
- Row dependence: w_0,1 = 0x80, everything else 0 except v1 = 0xFF, data x_r1 = 4r -> a_0 = 2r; y_r = (255*SIG[2r])>>8, checked against the reference model for all 64 rows.
- Handshake:
  - S_AXIS_TVALID gaps and M_AXIS_TREADY toggled 1-of-3 cycles -> identical results, no duplicated or lost words;
  - ARESETN pulsed at input word 200, then a full packet resent -> correct 64 outputs.
